// File: rtl/sw_bounce_gen.sv
`timescale 1ns/1ps
// Mechanical-switch bounce emulator: turns a clean level command into a burst of
// pseudo-random glitches, then a stable settled level and a one-cycle settled pulse.
module sw_bounce_gen #(
    parameter int          NUM_BOUNCES   = 6,
    parameter int          GLITCH_W      = 8,
    parameter int          SETTLE_CYCLES = 1000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    input  logic i_en,
    output logic o_sw,
    output logic o_busy,
    output logic o_settled
);

    localparam int          TOG_MAX  = 2 * NUM_BOUNCES;
    localparam int          TOG_W    = $clog2(TOG_MAX) + 1;
    localparam int          SEG_W    = GLITCH_W + 1;
    localparam int          SET_W    = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] TAP_MASK = 16'hB400;

    localparam logic [TOG_W-1:0] TOG_LOAD = TOG_W'(TOG_MAX);
    localparam logic [TOG_W-1:0] TOG_ONE  = TOG_W'(1);
    localparam logic [SEG_W-1:0] SEG_ONE  = SEG_W'(1);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES);
    localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t           state_reg,   state_next;
    logic             level_reg,   level_next;
    logic             sw_reg,      sw_next;
    logic             busy_reg,    busy_next;
    logic             settled_reg, settled_next;
    logic [TOG_W-1:0] tog_cnt_reg, tog_cnt_next;
    logic [SEG_W-1:0] seg_cnt_reg, seg_cnt_next;
    logic [SET_W-1:0] set_cnt_reg, set_cnt_next;
    logic [15:0]      lfsr_reg,    lfsr_next;
    logic [SEG_W-1:0] seg_load;

    // One feedback XOR per tapped bit; the shifted-out LSB feeds every tap.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lfsr
            if (gi == 15) begin : g_msb
                assign lfsr_next[gi] = TAP_MASK[gi] & lfsr_reg[0];
            end else begin : g_bit
                assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (TAP_MASK[gi] & lfsr_reg[0]);
            end
        end
    endgenerate

    assign seg_load = {1'b0, lfsr_reg[GLITCH_W-1:0]} + SEG_ONE;

    always_comb begin
        state_next   = state_reg;
        level_next   = level_reg;
        sw_next      = sw_reg;
        settled_next = 1'b0;
        tog_cnt_next = tog_cnt_reg;
        seg_cnt_next = seg_cnt_reg;
        set_cnt_next = set_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (i_level != level_reg) begin
                    level_next = i_level;
                    sw_next    = i_level;
                    if (i_en) begin
                        state_next   = BOUNCE;
                        tog_cnt_next = TOG_LOAD;
                        seg_cnt_next = seg_load;
                    end else begin
                        settled_next = 1'b1;
                    end
                end
            end
            BOUNCE: begin
                if (seg_cnt_reg == SEG_ONE) begin
                    sw_next      = ~sw_reg;
                    tog_cnt_next = tog_cnt_reg - TOG_ONE;
                    seg_cnt_next = seg_load;
                    // An even number of toggles leaves o_sw back at the new level
                    if (tog_cnt_reg == TOG_ONE) begin
                        state_next   = SETTLE;
                        set_cnt_next = SET_LOAD;
                    end
                end else begin
                    seg_cnt_next = seg_cnt_reg - SEG_ONE;
                end
            end
            SETTLE: begin
                if (set_cnt_reg == SET_ONE) begin
                    state_next   = IDLE;
                    settled_next = 1'b1;
                end else begin
                    set_cnt_next = set_cnt_reg - SET_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= IDLE;
            level_reg   <= 1'b0;
            sw_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            settled_reg <= 1'b0;
            tog_cnt_reg <= '0;
            seg_cnt_reg <= '0;
            set_cnt_reg <= '0;
            lfsr_reg    <= SEED_EFF;
        end else begin
            state_reg   <= state_next;
            level_reg   <= level_next;
            sw_reg      <= sw_next;
            busy_reg    <= busy_next;
            settled_reg <= settled_next;
            tog_cnt_reg <= tog_cnt_next;
            seg_cnt_reg <= seg_cnt_next;
            set_cnt_reg <= set_cnt_next;
            lfsr_reg    <= lfsr_next;
        end
    end

    assign o_sw      = sw_reg;
    assign o_busy    = busy_reg;
    assign o_settled = settled_reg;

endmodule

// File: tb/tb_sw_bounce_gen.sv
`timescale 1ns/1ps
// Scoreboard bench for sw_bounce_gen: a segment-level reference model predicts every
// o_sw edge, o_settled pulse and busy window; a negedge monitor pops and compares.
module tb_sw_bounce_gen;

    localparam int          NB   = 3;
    localparam int          GW   = 4;
    localparam int          SC   = 12;
    localparam logic [15:0] SEED = 16'h0000;
    localparam int          MAXC = 3000;
    localparam logic [15:0] MASK = 16'((1 << GW) - 1);

    typedef struct {
        int cyc;
        bit kind;   // 0 = o_sw edge, 1 = o_settled pulse
        bit val;
    } ev_t;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    logic i_level = 1'b0;
    logic i_en    = 1'b0;
    logic o_sw, o_busy, o_settled;

    ev_t         exp_q[$];
    bit          lvl_at [0:MAXC-1];
    bit          en_at  [0:MAXC-1];
    bit          busy_at[0:MAXC-1];
    logic [15:0] lf_arr [0:MAXC];
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    bit          mon_on = 1'b0;

    sw_bounce_gen #(
        .NUM_BOUNCES  (NB),
        .GLITCH_W     (GW),
        .SETTLE_CYCLES(SC),
        .LFSR_SEED    (SEED)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_level  (i_level),
        .i_en     (i_en),
        .o_sw     (o_sw),
        .o_busy   (o_busy),
        .o_settled(o_settled)
    );

    always #5 i_clk = ~i_clk;

    // Edges since reset release: during cycle after edge e, cyc == e
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic push_ev(input int c, input bit k, input bit v);
        ev_t x;
        x.cyc = c; x.kind = k; x.val = v;
        exp_q.push_back(x);
    endtask

    // Segment-level model: a level change seen at an idle edge either passes straight
    // through or launches 2*NB segments whose lengths come from the LFSR at their start.
    task automatic build_model(output int last);
        int e, s, len;
        bit r, v;
        last = 0;
        for (int k = 0; k < MAXC; k++) busy_at[k] = 1'b0;
        r = 1'b0;
        e = 1;
        while (e < MAXC - 300) begin
            if (lvl_at[e] != r) begin
                r = lvl_at[e];
                push_ev(e, 1'b0, r);
                if (!en_at[e]) begin
                    push_ev(e, 1'b1, r);
                    last = e;
                    e++;
                end else begin
                    s = e;
                    v = r;
                    for (int i = 0; i < 2 * NB; i++) begin
                        len = int'(lf_arr[s] & MASK) + 1;
                        s   = s + len;
                        v   = ~v;
                        push_ev(s, 1'b0, v);
                    end
                    for (int k = e; k < s + SC; k++) busy_at[k] = 1'b1;
                    push_ev(s + SC, 1'b1, r);
                    last = s + SC;
                    e    = s + SC + 1;
                end
            end else begin
                e++;
            end
        end
    endtask

    task automatic fill(input int lo, input int hi, input bit l, input bit en);
        for (int k = lo; k <= hi; k++) begin
            lvl_at[k] = l;
            en_at[k]  = en;
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (o_sw !== 1'b0) begin
            errors++;
            $display("FAIL %s o_sw: got %b required 0", name, o_sw);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s o_busy: got %b required 0", name, o_busy);
        end
        checks++;
        if (o_settled !== 1'b0) begin
            errors++;
            $display("FAIL %s o_settled: got %b required 0", name, o_settled);
        end
    endtask

    task automatic check_evt(input bit kind, input bit val);
        ev_t x;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got cyc=%0d kind=%0d sw=%0b required none", cyc, kind, val);
        end else begin
            x = exp_q.pop_front();
            if (x.cyc != cyc || x.kind != kind || x.val != val) begin
                errors++;
                $display("FAIL event: got cyc=%0d kind=%0d sw=%0b required cyc=%0d kind=%0d sw=%0b",
                         cyc, kind, val, x.cyc, x.kind, x.val);
            end else begin
                $display("event cyc=%0d kind=%s sw=%0b ok", cyc, kind ? "settled" : "edge", val);
            end
        end
    endtask

    // Monitor: compares outputs on the falling edge, away from the active edge
    initial begin
        bit prev_sw;
        prev_sw = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n || !mon_on || cyc >= MAXC) begin
                prev_sw = 1'b0;
            end else begin
                checks++;
                if (o_busy !== busy_at[cyc]) begin
                    errors++;
                    $display("FAIL busy cyc=%0d: got %b required %b", cyc, o_busy, busy_at[cyc]);
                end
                checks++;
                if (o_busy === 1'b1 && o_settled === 1'b1) begin
                    errors++;
                    $display("FAIL busy_settled_overlap cyc=%0d: got both 1 required not both", cyc);
                end
                if (o_sw !== prev_sw) check_evt(1'b0, o_sw);
                if (o_settled === 1'b1) check_evt(1'b1, o_sw);
                prev_sw = o_sw;
            end
        end
    end

    // Reset, model, drive one plan; stop_at != 0 fires an async reset after that edge
    task automatic run_plan(input string name, input int ncyc, input int stop_at);
        int last, dur;
        mon_on  = 1'b0;
        i_rst_n = 1'b0;
        for (int k = ncyc + 1; k < MAXC; k++) begin
            lvl_at[k] = lvl_at[ncyc];
            en_at[k]  = en_at[ncyc];
        end
        exp_q.delete();
        build_model(last);
        dur     = ((last > ncyc) ? last : ncyc) + 3;
        i_level = lvl_at[1];
        i_en    = en_at[1];
        #1;
        check_zero({name, "_in_reset"});
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        mon_on  = 1'b1;
        for (int e = 1; e <= dur; e++) begin
            i_level = lvl_at[e];
            i_en    = en_at[e];
            @(posedge i_clk);
            @(negedge i_clk);
            if (stop_at != 0 && e == stop_at) begin
                #2;
                mon_on  = 1'b0;
                i_rst_n = 1'b0;
                #1;
                check_zero({name, "_async_reset"});
                return;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s leftover: got %0d pending events required 0 (next cyc=%0d)",
                     name, exp_q.size(), exp_q[0].cyc);
        end
    endtask

    task automatic plan_random(input int ncyc);
        int e, hold, hi;
        bit l, en;
        e = 1;
        while (e <= ncyc) begin
            hold = $urandom_range(1, 40);
            l    = 1'($urandom_range(0, 1));
            en   = ($urandom_range(0, 3) != 0);
            hi   = (e + hold - 1 > ncyc) ? ncyc : e + hold - 1;
            fill(e, hi, l, en);
            e = e + hold;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish required finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        lf_arr[0] = 16'h0000;
        lf_arr[1] = (SEED == 16'h0000) ? 16'h0001 : SEED;
        for (int k = 2; k <= MAXC; k++) lf_arr[k] = lfsr_step(lf_arr[k-1]);

        // level held high through reset, clean mode
        fill(1, 5, 1'b1, 1'b0);
        run_plan("reset_release", 5, 0);

        // clean pass-through 0->1->0 with 5-cycle spacing
        fill(1, 3, 1'b0, 1'b0); fill(4, 8, 1'b1, 1'b0); fill(9, 15, 1'b0, 1'b0);
        run_plan("passthrough", 15, 0);

        // one bounce burst 0->1
        fill(1, 2, 1'b0, 1'b1); fill(3, 10, 1'b1, 1'b1);
        run_plan("bounce", 10, 0);

        // short low pulse mid-burst is ignored
        fill(1, 2, 1'b0, 1'b1); fill(3, 5, 1'b1, 1'b1); fill(6, 8, 1'b0, 1'b1); fill(9, 12, 1'b1, 1'b1);
        run_plan("pulse_ignored", 12, 0);

        // low held mid-burst starts a second burst; i_en drops mid-sequence
        fill(1, 2, 1'b0, 1'b1); fill(3, 3, 1'b1, 1'b1); fill(4, 5, 1'b1, 1'b0); fill(6, 12, 1'b0, 1'b1);
        run_plan("held_second", 12, 0);

        // async reset right after the burst starts, then an identical re-run
        fill(1, 2, 1'b0, 1'b1); fill(3, 10, 1'b1, 1'b1);
        run_plan("mid_reset", 10, 3);
        fill(1, 2, 1'b0, 1'b1); fill(3, 10, 1'b1, 1'b1);
        run_plan("rerun", 10, 0);

        for (int r = 0; r < 6; r++) begin
            plan_random(500);
            run_plan("random", 500, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
